// File: rtl/dmem_pkg.sv
// Shared types and constants for the data memory slice.
// Holds the init FSM states and the DMEM_PRELOAD_EN preload table.
package dmem_pkg;

  typedef enum logic {
    INIT,
    RUN
  } dmem_state_e;

  localparam int PRELOAD_LEN = 24;

  localparam logic [7:0] PRELOAD [PRELOAD_LEN] = '{
    8'h00, 8'h0C, 8'h11, 8'h11,
    8'h33, 8'h44, 8'h55, 8'h66,
    8'hFF, 8'h00, 8'h00, 8'h00,
    8'h00, 8'hFF, 8'h00, 8'h00,
    8'h00, 8'h00, 8'hFF, 8'h00,
    8'h00, 8'h00, 8'h00, 8'hFF
  };

  function automatic logic [7:0] preload_byte(
    input logic [31:0] a
  );
    logic [4:0] k;
    k = a[4:0];
    if (a < 32'(PRELOAD_LEN))
      return PRELOAD[k];
    return 8'h00;
  endfunction

endpackage

// File: rtl/data_memory_pipe_if.sv
// Load/store (A) and pixel-fetch (B) bus of the data memory.
// master = requester, slave = memory; carries ready too.
interface data_memory_pipe_if #(
  parameter int ADDR_W     = 16,
  parameter int WORD_BYTES = 4
);

  logic                    ready;
  logic                    a_req;
  logic                    a_we;
  logic [ADDR_W-1:0]       a_addr;
  logic [WORD_BYTES-1:0]   a_be;
  logic [8*WORD_BYTES-1:0] a_wdata;
  logic [8*WORD_BYTES-1:0] a_rdata;
  logic                    a_rvalid;
  logic                    b_req;
  logic [ADDR_W-1:0]       b_addr;
  logic [7:0]              b_rdata;
  logic                    b_rvalid;

  modport master (
    input  ready, a_rdata, a_rvalid,
    input  b_rdata, b_rvalid,
    output a_req, a_we, a_addr, a_be,
    output a_wdata, b_req, b_addr
  );

  modport slave (
    output ready, a_rdata, a_rvalid,
    output b_rdata, b_rvalid,
    input  a_req, a_we, a_addr, a_be,
    input  a_wdata, b_req, b_addr
  );

endinterface

// File: rtl/dmem_init_seq.sv
// Init sequencer: walks every byte once after rst, then raises ready.
// Ports: clk, rst, ready, init_we/addr/data. Macro: DMEM_PRELOAD_EN.
module dmem_init_seq
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  output logic              ready,
  output logic              init_we,
  output logic [ADDR_W-1:0] init_addr,
  output logic [7:0]        init_data
);

  dmem_state_e       state;
  logic [ADDR_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= INIT;
      cnt   <= '0;
      ready <= 1'b0;
    end else begin
      unique case (state)
        INIT: begin
          cnt <= cnt + 1'b1;
          if (&cnt) begin
            state <= RUN;
            ready <= 1'b1;
          end
        end
        RUN: ;
      endcase
    end
  end

  assign init_we   = (state == INIT) && !rst;
  assign init_addr = cnt;

`ifdef DMEM_PRELOAD_EN
  assign init_data = preload_byte(32'(cnt));
`else
  assign init_data = 8'h00;
`endif

endmodule

// File: rtl/data_memory_pipe.sv
// Byte-addressed data memory: word port A (load/store), byte port B.
// Ports: clk, rst, bus (slave). RD_LAT 1|2. Macro: DMEM_PRELOAD_EN.
module data_memory_pipe
  import dmem_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int WORD_BYTES = 4,
  parameter int RD_LAT     = 1
) (
  input  logic clk,
  input  logic rst,
  data_memory_pipe_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int DW    = 8 * WORD_BYTES;

  logic [7:0]        mem [DEPTH];
  logic              ready;
  logic              init_we;
  logic [ADDR_W-1:0] init_addr;
  logic [7:0]        init_data;

  logic              a_wr;
  logic              a_rd;
  logic              b_rd;
  logic [ADDR_W-1:0] lane_addr [WORD_BYTES];
  logic [DW-1:0]     a_word;
  logic [7:0]        b_byte;

  logic              a_v1;
  logic              b_v1;
  logic [DW-1:0]     a_d1;
  logic [7:0]        b_d1;

  dmem_init_seq #(
    .ADDR_W(ADDR_W)
  ) u_init (
    .clk      (clk),
    .rst      (rst),
    .ready    (ready),
    .init_we  (init_we),
    .init_addr(init_addr),
    .init_data(init_data)
  );

  assign bus.ready = ready;

  assign a_wr = ready && bus.a_req && bus.a_we;
  assign a_rd = ready && bus.a_req && !bus.a_we;
  assign b_rd = ready && bus.b_req;

  // Lane addresses wrap modulo DEPTH by width.
  always_comb begin
    for (int i = 0; i < WORD_BYTES; i++)
      lane_addr[i] = bus.a_addr + ADDR_W'(i);
  end

  always_comb begin
    a_word = '0;
    for (int i = 0; i < WORD_BYTES; i++)
      a_word[8*i +: 8] = mem[lane_addr[i]];
  end

  // Port B sees a same-cycle port-A write (write-first).
  always_comb begin
    b_byte = mem[bus.b_addr];
    for (int i = 0; i < WORD_BYTES; i++)
      if (a_wr && bus.a_be[i] &&
          lane_addr[i] == bus.b_addr)
        b_byte = bus.a_wdata[8*i +: 8];
  end

  always_ff @(posedge clk) begin
    if (init_we) begin
      mem[init_addr] <= init_data;
    end else if (a_wr) begin
      for (int i = 0; i < WORD_BYTES; i++)
        if (bus.a_be[i])
          mem[lane_addr[i]] <= bus.a_wdata[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_v1 <= 1'b0;
      b_v1 <= 1'b0;
      a_d1 <= '0;
      b_d1 <= '0;
    end else begin
      a_v1 <= a_rd;
      b_v1 <= b_rd;
      if (a_rd) a_d1 <= a_word;
      if (b_rd) b_d1 <= b_byte;
    end
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic          a_v2;
      logic          b_v2;
      logic [DW-1:0] a_d2;
      logic [7:0]    b_d2;

      always_ff @(posedge clk) begin
        if (rst) begin
          a_v2 <= 1'b0;
          b_v2 <= 1'b0;
          a_d2 <= '0;
          b_d2 <= '0;
        end else begin
          a_v2 <= a_v1;
          b_v2 <= b_v1;
          if (a_v1) a_d2 <= a_d1;
          if (b_v1) b_d2 <= b_d1;
        end
      end

      assign bus.a_rvalid = a_v2;
      assign bus.a_rdata  = a_d2;
      assign bus.b_rvalid = b_v2;
      assign bus.b_rdata  = b_d2;
    end else begin : g_lat1
      assign bus.a_rvalid = a_v1;
      assign bus.a_rdata  = a_d1;
      assign bus.b_rvalid = b_v1;
      assign bus.b_rdata  = b_d1;
    end
  endgenerate

endmodule

// File: tb/tb_data_memory_pipe.sv
// Bench for data_memory_pipe: RD_LAT=1 and RD_LAT=2 copies, same stimulus.
// Reference model is a byte array plus a response delay line.
module tb_data_memory_pipe;

  localparam int AW = 6;
  localparam int DP = 64;

`ifdef DMEM_PRELOAD_EN
  localparam logic [31:0] INIT_W0 = 32'h11110C00;
`else
  localparam logic [31:0] INIT_W0 = 32'h00000000;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          a_req = 1'b0;
  logic          a_we = 1'b0;
  logic [AW-1:0] a_addr = '0;
  logic [3:0]    a_be = '0;
  logic [31:0]   a_wdata = '0;
  logic          b_req = 1'b0;
  logic [AW-1:0] b_addr = '0;

  data_memory_pipe_if #(.ADDR_W(AW), .WORD_BYTES(4)) if1 ();
  data_memory_pipe_if #(.ADDR_W(AW), .WORD_BYTES(4)) if2 ();

  assign if1.a_req   = a_req;
  assign if1.a_we    = a_we;
  assign if1.a_addr  = a_addr;
  assign if1.a_be    = a_be;
  assign if1.a_wdata = a_wdata;
  assign if1.b_req   = b_req;
  assign if1.b_addr  = b_addr;
  assign if2.a_req   = a_req;
  assign if2.a_we    = a_we;
  assign if2.a_addr  = a_addr;
  assign if2.a_be    = a_be;
  assign if2.a_wdata = a_wdata;
  assign if2.b_req   = b_req;
  assign if2.b_addr  = b_addr;

  data_memory_pipe #(.ADDR_W(AW), .WORD_BYTES(4), .RD_LAT(1)) u1 (
    .clk(clk), .rst(rst), .bus(if1)
  );
  data_memory_pipe #(.ADDR_W(AW), .WORD_BYTES(4), .RD_LAT(2)) u2 (
    .clk(clk), .rst(rst), .bus(if2)
  );

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0]  m_mem [DP];
  bit          m_ready = 0;
  int          m_cnt = 0;
  bit          e1_av, e1_bv, e2_av, e2_bv, p_av, p_bv;
  logic [31:0] e1_ad, e2_ad, p_ad;
  logic [7:0]  e1_bd, e2_bd, p_bd;

  function automatic logic [7:0] init_byte(int j);
`ifdef DMEM_PRELOAD_EN
    case (j)
      1: return 8'h0C;
      2, 3: return 8'h11;
      4: return 8'h33;
      5: return 8'h44;
      6: return 8'h55;
      7: return 8'h66;
      8, 13, 18, 23: return 8'hFF;
      default: return 8'h00;
    endcase
`else
    return 8'h00;
`endif
  endfunction

  // One clock: advance the model with the inputs present at the edge.
  task automatic tick();
    bit          rdy;
    bit          ra_v, rb_v;
    logic [31:0] ra_d;
    logic [7:0]  rb_d;
    rdy = m_ready;
    @(posedge clk);
    if (rst) begin
      for (int j = 0; j < DP; j++) m_mem[j] = init_byte(j);
      m_ready = 0; m_cnt = 0;
      e1_av = 0; e1_bv = 0; e2_av = 0; e2_bv = 0;
      p_av = 0; p_bv = 0;
      e1_ad = 0; e2_ad = 0; p_ad = 0;
      e1_bd = 0; e2_bd = 0; p_bd = 0;
    end else begin
      ra_v = rdy && a_req && !a_we;
      rb_v = rdy && b_req;
      if (rdy && a_req && a_we)
        for (int i = 0; i < 4; i++)
          if (a_be[i])
            m_mem[(int'(a_addr) + i) % DP] = a_wdata[8*i +: 8];
      for (int i = 0; i < 4; i++)
        ra_d[8*i +: 8] = m_mem[(int'(a_addr) + i) % DP];
      rb_d = m_mem[b_addr];
      e2_av = p_av; if (p_av) e2_ad = p_ad;
      e2_bv = p_bv; if (p_bv) e2_bd = p_bd;
      p_av = ra_v; if (ra_v) p_ad = ra_d;
      p_bv = rb_v; if (rb_v) p_bd = rb_d;
      e1_av = ra_v; if (ra_v) e1_ad = ra_d;
      e1_bv = rb_v; if (rb_v) e1_bd = rb_d;
      if (!m_ready) begin
        m_cnt++;
        if (m_cnt == DP) m_ready = 1;
      end
    end
    #1;
  endtask

  task automatic idle();
    a_req = 0; a_we = 0; b_req = 0; a_be = '0;
  endtask

  task automatic test_reset();
    rst = 1; idle();
    repeat (3) tick();
    n_assert++;
    if ({if1.ready, if1.a_rvalid, if1.b_rvalid} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_flags1 got %b want 000",
        {if1.ready, if1.a_rvalid, if1.b_rvalid});
    end
    n_assert++;
    if ({if2.ready, if2.a_rvalid, if2.b_rvalid} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_flags2 got %b want 000",
        {if2.ready, if2.a_rvalid, if2.b_rvalid});
    end
    n_assert++;
    if ({if1.a_rdata, if1.b_rdata, if2.a_rdata, if2.b_rdata} !== 80'h0) begin
      n_fail++;
      $display("FAIL reset_data got %h want 0",
        {if1.a_rdata, if1.b_rdata, if2.a_rdata, if2.b_rdata});
    end
    rst = 0;
    for (int c = 1; c <= DP; c++) begin
      tick();
      n_assert++;
      if ({if1.ready, if2.ready} !== {2{c == DP}}) begin
        n_fail++;
        $display("FAIL ready_rise cyc %0d got %b want %b",
          c, {if1.ready, if2.ready}, {2{c == DP}});
      end
    end
    a_req = 1; a_we = 0; a_addr = 0;
    tick(); idle();
    n_assert++;
    if ({if1.a_rvalid, if1.a_rdata} !== {1'b1, INIT_W0}) begin
      n_fail++;
      $display("FAIL init_word0_l1 got %b/%h want 1/%h",
        if1.a_rvalid, if1.a_rdata, INIT_W0);
    end
    tick();
    n_assert++;
    if ({if2.a_rvalid, if2.a_rdata, if1.a_rvalid} !== {1'b1, INIT_W0, 1'b0}) begin
      n_fail++;
      $display("FAIL init_word0_l2 got %b/%h/%b want 1/%h/0",
        if2.a_rvalid, if2.a_rdata, if1.a_rvalid, INIT_W0);
    end
    tick();
  endtask

  task automatic test_before_ready();
    rst = 1; idle(); tick(); rst = 0;
    for (int c = 1; c <= DP; c++) begin
      if (c == 10) begin
        a_req = 1; a_we = 1; a_addr = 0;
        a_be = 4'hF; a_wdata = 32'hDEADBEEF;
        b_req = 1; b_addr = 0;
      end else if (c == 11) begin
        a_req = 1; a_we = 0; b_req = 0;
      end else idle();
      tick();
      n_assert++;
      if ({if1.a_rvalid, if1.b_rvalid, if2.a_rvalid, if2.b_rvalid} !== 4'b0) begin
        n_fail++;
        $display("FAIL early_req_rvalid cyc %0d got %b want 0000",
          c, {if1.a_rvalid, if1.b_rvalid, if2.a_rvalid, if2.b_rvalid});
      end
    end
    idle();
    a_req = 1; a_addr = 0;
    tick(); idle();
    n_assert++;
    if (if1.a_rdata !== INIT_W0) begin
      n_fail++;
      $display("FAIL early_write_ignored got %h want %h", if1.a_rdata, INIT_W0);
    end
    tick();
  endtask

  task automatic test_byte_enable();
    a_req = 1; a_we = 1; a_addr = 8;
    a_wdata = 32'hAABBCCDD; a_be = 4'b0101;
    tick();
    a_we = 0; a_be = 0;
    tick(); idle();
    n_assert++;
    if ({if1.a_rvalid, if1.a_rdata} !== {1'b1, 32'h00BB00DD}) begin
      n_fail++;
      $display("FAIL byte_enable got %b/%h want 1/00bb00dd",
        if1.a_rvalid, if1.a_rdata);
    end
    a_req = 1; a_we = 1; a_be = 4'b0000; a_wdata = 32'h12345678;
    tick();
    a_we = 0;
    tick(); idle();
    n_assert++;
    if (if1.a_rdata !== 32'h00BB00DD) begin
      n_fail++;
      $display("FAIL be_zero_noop got %h want 00bb00dd", if1.a_rdata);
    end
    tick();
  endtask

  task automatic test_wrap();
    a_req = 1; a_we = 1; a_addr = 62;
    a_wdata = 32'h44332211; a_be = 4'hF;
    tick(); idle();
    b_req = 1; b_addr = 63;
    tick();
    n_assert++;
    if ({if1.b_rvalid, if1.b_rdata} !== {1'b1, 8'h22}) begin
      n_fail++;
      $display("FAIL wrap_b63 got %b/%h want 1/22", if1.b_rvalid, if1.b_rdata);
    end
    b_addr = 0; a_req = 1; a_we = 0; a_addr = 62;
    tick(); idle();
    n_assert++;
    if ({if1.b_rdata, if1.a_rdata} !== {8'h33, 32'h44332211}) begin
      n_fail++;
      $display("FAIL wrap_read got %h/%h want 33/44332211",
        if1.b_rdata, if1.a_rdata);
    end
    tick();
    n_assert++;
    if ({if2.b_rvalid, if2.b_rdata, if2.a_rdata} !== {1'b1, 8'h33, 32'h44332211}) begin
      n_fail++;
      $display("FAIL wrap_read_l2 got %b/%h/%h want 1/33/44332211",
        if2.b_rvalid, if2.b_rdata, if2.a_rdata);
    end
  endtask

  task automatic test_forward();
    a_req = 1; a_we = 1; a_addr = 5;
    a_be = 4'b0001; a_wdata = 32'h0000007E;
    b_req = 1; b_addr = 5;
    tick(); idle();
    n_assert++;
    if ({if1.b_rvalid, if1.b_rdata, if2.b_rvalid} !== {1'b1, 8'h7E, 1'b0}) begin
      n_fail++;
      $display("FAIL fwd_l1 got %b/%h/%b want 1/7e/0",
        if1.b_rvalid, if1.b_rdata, if2.b_rvalid);
    end
    tick();
    n_assert++;
    if ({if2.b_rvalid, if2.b_rdata, if1.b_rvalid, if1.b_rdata} !==
        {1'b1, 8'h7E, 1'b0, 8'h7E}) begin
      n_fail++;
      $display("FAIL fwd_l2 got %b/%h/%b/%h want 1/7e/0/7e",
        if2.b_rvalid, if2.b_rdata, if1.b_rvalid, if1.b_rdata);
    end
    tick();
  endtask

  task automatic test_reset_mid_read();
    a_req = 1; a_we = 0; a_addr = 4;
    tick(); idle();
    rst = 1;
    tick(); rst = 0;
    for (int c = 1; c <= 30; c++) begin
      n_assert++;
      if ({if2.a_rvalid, if1.a_rvalid, if1.ready} !== 3'b000) begin
        n_fail++;
        $display("FAIL rst_mid_read cyc %0d got %b want 000",
          c, {if2.a_rvalid, if1.a_rvalid, if1.ready});
      end
      tick();
    end
    rst = 1; tick(); rst = 0;
    for (int c = 1; c <= DP; c++) begin
      tick();
      n_assert++;
      if ({if1.ready, if2.ready} !== {2{c == DP}}) begin
        n_fail++;
        $display("FAIL rst_mid_init cyc %0d got %b want %b",
          c, {if1.ready, if2.ready}, {2{c == DP}});
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      a_req   = ($urandom_range(0, 3) != 0);
      a_we    = $urandom_range(0, 1);
      a_addr  = AW'($urandom);
      a_be    = 4'($urandom);
      a_wdata = $urandom;
      b_req   = ($urandom_range(0, 3) != 0);
      b_addr  = ($urandom_range(0, 1) != 0) ?
                AW'(a_addr + AW'($urandom_range(0, 3))) : AW'($urandom);
      tick();
      n_assert++;
      if ({if1.a_rvalid, if1.a_rdata} !== {e1_av, e1_ad}) begin
        n_fail++;
        $display("FAIL rnd_a_l1 cyc %0d got %b/%h want %b/%h",
          c, if1.a_rvalid, if1.a_rdata, e1_av, e1_ad);
      end
      n_assert++;
      if ({if1.b_rvalid, if1.b_rdata} !== {e1_bv, e1_bd}) begin
        n_fail++;
        $display("FAIL rnd_b_l1 cyc %0d got %b/%h want %b/%h",
          c, if1.b_rvalid, if1.b_rdata, e1_bv, e1_bd);
      end
      n_assert++;
      if ({if2.a_rvalid, if2.a_rdata} !== {e2_av, e2_ad}) begin
        n_fail++;
        $display("FAIL rnd_a_l2 cyc %0d got %b/%h want %b/%h",
          c, if2.a_rvalid, if2.a_rdata, e2_av, e2_ad);
      end
      n_assert++;
      if ({if2.b_rvalid, if2.b_rdata} !== {e2_bv, e2_bd}) begin
        n_fail++;
        $display("FAIL rnd_b_l2 cyc %0d got %b/%h want %b/%h",
          c, if2.b_rvalid, if2.b_rdata, e2_bv, e2_bd);
      end
      n_assert++;
      if ({if1.ready, if2.ready} !== {2{m_ready}}) begin
        n_fail++;
        $display("FAIL rnd_ready cyc %0d got %b want %b",
          c, {if1.ready, if2.ready}, {2{m_ready}});
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_before_ready();
    test_byte_enable();
    test_wrap();
    test_forward();
    test_reset_mid_read();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
      n_assert, n_fail);
    $finish;
  end

endmodule
